isa_decode_stage: RTL and testbench

Parametrised, registered successor to the single-cycle instruction decoder. It accepts instructions over a valid/ready handshake and splits them into opcode, register addresses and immediate. It produces per-class enables, supports free-running and button-stepped issue, and halts on a HALT opcode. It sits between instruction fetch and the register file / ALU and provides one pipeline register of decode.

---
 rtl/isa_pkg.sv | 42 ++++
 rtl/isa_decode_stage_btn_step_sync.sv | 39 +++
 rtl/isa_decode_stage.sv | 182 ++++++++++++++++++
 tb/tb_isa_decode_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// isa_pkg
// Shared decode definitions for the ISA decode stage and its neighbours.
// Holds the opcode constants, the opcode class enum, and helpers that derive
// the opcode class and the instruction field positions from the widths in use.
package isa_pkg;

   // Opcode class seen by the register file / ALU
   typedef enum logic [1:0] {
      CLS_NOP,
      CLS_LDI,
      CLS_ALU,
      CLS_HALT
   } op_class_e;

   localparam int OP_W_DEFAULT = 4;
   localparam int OP_NOP       = 0;
   localparam int OP_LDI       = 1;
   // HALT is the all-ones opcode; this constant is for the default opcode width
   // and op_halt() gives the value for any other width.
   localparam int OP_HALT      = (1 << OP_W_DEFAULT) - 1;

   // All-ones opcode for an opcode field op_w bits wide
   function automatic int op_halt(input int op_w);
      return (1 << op_w) - 1;
   endfunction

   // Map an opcode value to its class; everything between LDI and HALT is ALU
   function automatic op_class_e op_class(input logic [31:0] op, input int op_w);
      if (op == 32'(OP_NOP)) return CLS_NOP;
      if (op == 32'(OP_LDI)) return CLS_LDI;
      if (op == 32'(op_halt(op_w))) return CLS_HALT;
      return CLS_ALU;
   endfunction

   // LSB position of a field: slot 0 is the opcode, slot 1 rd, slot 2 rs,
   // each packed directly below the previous one from the top of the word
   function automatic int field_lsb(input int instr_w, input int op_w,
                                    input int reg_aw, input int slot);
      return instr_w - op_w - slot * reg_aw;
   endfunction

endpackage

// File: rtl/isa_decode_stage_btn_step_sync.sv
// btn_step_sync
// Front-panel button conditioner: brings an asynchronous button into the clock
// domain through a two-flop synchroniser and emits a single-cycle pulse on each
// rising edge. The pulse itself is registered, so a press shows up three clock
// edges after the button rises.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   btn        - raw asynchronous button level
//   step_pulse - one-cycle pulse per button press
module btn_step_sync (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic step_pulse
);

   logic sync1;
   logic sync2;
   logic sync2_d;

   // Synchroniser chain, a delayed copy for edge detection, and the
   // registered edge pulse; all cleared so a held button after reset
   // still reads as a fresh press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         sync2_d    <= 1'b0;
         step_pulse <= 1'b0;
      end else begin
         sync1      <= btn;
         sync2      <= sync1;
         sync2_d    <= sync2;
         step_pulse <= sync2 & ~sync2_d;
      end
   end

endmodule

// File: rtl/isa_decode_stage.sv
// isa_decode_stage
// One registered pipeline stage of instruction decode between fetch and the
// register file / ALU. Instructions arrive on a valid/ready handshake, are
// split into opcode, register addresses and immediate, and the class enables
// are produced alongside. Issue is either free running or one instruction per
// button press, and the stage freezes after a HALT is accepted.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   instr, instr_valid       - incoming instruction and its valid
//   instr_ready              - stage accepts an instruction this cycle
//   btn, step_mode           - raw step button, 1 = button-stepped issue
//   dec_valid, dec_ready     - downstream handshake for the decoded outputs
//   opcode, rd_addr, rs_addr, imm - decoded fields
//   rd_en, rs_en, wr_en, imm_en   - class enables
//   halted                   - HALT accepted, stage frozen
//   retired                  - count of instructions handed downstream
module isa_decode_stage
   import isa_pkg::*;
#(
   parameter int INSTR_W = 16,
   parameter int OP_W    = 4,
   parameter int REG_AW  = 4,
   parameter int IMM_W   = 8,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic               btn,
   input  logic               step_mode,
   output logic               dec_valid,
   input  logic               dec_ready,
   output logic [OP_W-1:0]    opcode,
   output logic [REG_AW-1:0]  rd_addr,
   output logic [REG_AW-1:0]  rs_addr,
   output logic [IMM_W-1:0]   imm,
   output logic               rd_en,
   output logic               rs_en,
   output logic               wr_en,
   output logic               imm_en,
   output logic               halted,
   output logic [CNT_W-1:0]   retired
);

   localparam int OP_LSB = field_lsb(INSTR_W, OP_W, REG_AW, 0);
   localparam int RD_LSB = field_lsb(INSTR_W, OP_W, REG_AW, 1);
   localparam int RS_LSB = field_lsb(INSTR_W, OP_W, REG_AW, 2);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_STEP_WAIT,
      ST_STEP_GO,
      ST_HALTED
   } state_e;

   state_e            state;
   logic              token;
   logic              step_pulse;
   logic              accept;
   logic              can_issue;

   logic [OP_W-1:0]   dec_op;
   logic [REG_AW-1:0] dec_rd;
   logic [REG_AW-1:0] dec_rs;
   logic [IMM_W-1:0]  dec_imm;
   op_class_e         dec_cls;
   logic              dec_rd_en;
   logic              dec_rs_en;
   logic              dec_wr_en;
   logic              dec_imm_en;

   btn_step_sync u_btn_step_sync (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn),
      .step_pulse (step_pulse)
   );

   assign dec_op  = instr[OP_LSB +: OP_W];
   assign dec_rd  = instr[RD_LSB +: REG_AW];
   assign dec_rs  = instr[RS_LSB +: REG_AW];
   assign dec_imm = instr[IMM_W-1:0];
   assign dec_cls = op_class(32'(dec_op), OP_W);

   // Class enables for the incoming instruction; NOP and HALT touch nothing
   always_comb begin
      dec_rd_en  = 1'b0;
      dec_rs_en  = 1'b0;
      dec_wr_en  = 1'b0;
      dec_imm_en = 1'b0;
      case (dec_cls)
         CLS_LDI: begin
            dec_rd_en  = 1'b1;
            dec_wr_en  = 1'b1;
            dec_imm_en = 1'b1;
         end
         CLS_ALU: begin
            dec_rd_en = 1'b1;
            dec_rs_en = 1'b1;
            dec_wr_en = 1'b1;
         end
         default: ;
      endcase
   end

   // Ready is forced low while reset is applied so nothing can be taken
   // in the reset cycle; otherwise we issue when the mode allows it and the
   // output register is empty or being drained this cycle.
   assign can_issue   = (state == ST_RUN) || (state == ST_STEP_GO);
   assign instr_ready = !rst && can_issue && (!dec_valid || dec_ready);
   assign accept      = instr_valid && instr_ready;

   // Issue-control FSM with the step token and the halted flag. The token
   // is set by a press (even while already set, so a press coinciding with
   // an acceptance is kept for the next step), consumed by an acceptance and
   // dropped whenever step mode is off. HALTED is left only through reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_RUN;
         token  <= 1'b0;
         halted <= 1'b0;
      end else begin
         case (state)
            ST_HALTED: begin
               state <= ST_HALTED;
               token <= 1'b0;
            end
            default: begin
               token <= step_mode && (step_pulse || (token && !accept));
               if (accept && dec_cls == CLS_HALT) begin
                  state  <= ST_HALTED;
                  halted <= 1'b1;
               end else if (!step_mode) begin
                  state <= ST_RUN;
               end else if (step_pulse || (token && !accept)) begin
                  state <= ST_STEP_GO;
               end else begin
                  state <= ST_STEP_WAIT;
               end
            end
         endcase
      end
   end

   // Decode output register and retired counter. The register only loads on
   // acceptance, so it holds while downstream stalls; valid drops when the
   // held entry is consumed with nothing new behind it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_valid <= 1'b0;
         opcode    <= '0;
         rd_addr   <= '0;
         rs_addr   <= '0;
         imm       <= '0;
         rd_en     <= 1'b0;
         rs_en     <= 1'b0;
         wr_en     <= 1'b0;
         imm_en    <= 1'b0;
         retired   <= '0;
      end else begin
         if (accept) begin
            dec_valid <= 1'b1;
            opcode    <= dec_op;
            rd_addr   <= dec_rd;
            rs_addr   <= dec_rs;
            imm       <= dec_imm;
            rd_en     <= dec_rd_en;
            rs_en     <= dec_rs_en;
            wr_en     <= dec_wr_en;
            imm_en    <= dec_imm_en;
         end else if (dec_ready) begin
            dec_valid <= 1'b0;
         end
         if (dec_valid && dec_ready) begin
            retired <= retired + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_isa_decode_stage.sv
// tb_isa_decode_stage
// Self-checking bench for isa_decode_stage. A second instance with a 2-bit
// retired counter shares all inputs to exercise counter wrap. The reference
// model tracks the held instruction, the step token, the halted flag and a
// short history of sampled button levels, and predicts every output each cycle.
module tb_isa_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr;
   logic        instr_valid;
   logic        btn;
   logic        step_mode;
   logic        dec_ready;

   logic        instr_ready, dec_valid, halted;
   logic [3:0]  opcode, rd_addr, rs_addr;
   logic [7:0]  imm;
   logic        rd_en, rs_en, wr_en, imm_en;
   logic [15:0] retired;

   logic        u2_instr_ready, u2_dec_valid, u2_halted;
   logic [3:0]  u2_opcode, u2_rd_addr, u2_rs_addr;
   logic [7:0]  u2_imm;
   logic        u2_rd_en, u2_rs_en, u2_wr_en, u2_imm_en;
   logic [1:0]  u2_retired;

   int          checks = 0;
   int          failures = 0;

   logic [15:0] m_instr;
   logic        m_valid, m_halted, m_token, m_prev_mode, exp_ready;
   logic [3:0]  m_hist;
   logic [31:0] m_count;

   always #5 clk = ~clk;

   isa_decode_stage dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .btn(btn), .step_mode(step_mode),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .opcode(opcode),
      .rd_addr(rd_addr), .rs_addr(rs_addr), .imm(imm), .rd_en(rd_en),
      .rs_en(rs_en), .wr_en(wr_en), .imm_en(imm_en), .halted(halted),
      .retired(retired)
   );

   isa_decode_stage #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(u2_instr_ready), .btn(btn), .step_mode(step_mode),
      .dec_valid(u2_dec_valid), .dec_ready(dec_ready), .opcode(u2_opcode),
      .rd_addr(u2_rd_addr), .rs_addr(u2_rs_addr), .imm(u2_imm), .rd_en(u2_rd_en),
      .rs_en(u2_rs_en), .wr_en(u2_wr_en), .imm_en(u2_imm_en), .halted(u2_halted),
      .retired(u2_retired)
   );

   // Enables {rd, rs, wr, imm} from the opcode class table
   function automatic logic [3:0] expEnables(input logic [15:0] w);
      logic [3:0] op;
      op = w[15:12];
      if (op == 4'h0 || op == 4'hF) return 4'b0000;
      if (op == 4'h1) return 4'b1011;
      return 4'b1110;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_instr = '0; m_valid = 0; m_halted = 0; m_token = 0;
      m_prev_mode = 0; m_hist = '0; m_count = '0;
   endtask

   // Compare every observable output against the model state
   task automatic checkAll();
      exp_ready = !rst && !m_halted && (!m_prev_mode || m_token) &&
                  (!m_valid || dec_ready);
      checkOutput("instr_ready", 32'(instr_ready), 32'(exp_ready));
      checkOutput("dec_valid", 32'(dec_valid), 32'(m_valid));
      checkOutput("halted", 32'(halted), 32'(m_halted));
      checkOutput("retired", 32'(retired), 32'(m_count[15:0]));
      checkOutput("retired_w2", 32'(u2_retired), 32'(m_count[1:0]));
      checkOutput("opcode", 32'(opcode), 32'(m_instr[15:12]));
      checkOutput("rd_addr", 32'(rd_addr), 32'(m_instr[11:8]));
      checkOutput("rs_addr", 32'(rs_addr), 32'(m_instr[7:4]));
      checkOutput("imm", 32'(imm), 32'(m_instr[7:0]));
      checkOutput("enables", 32'({rd_en, rs_en, wr_en, imm_en}),
                  32'(expEnables(m_instr)));
   endtask

   // Drive one cycle of inputs at the falling edge, check, then advance the
   // model across the rising edge
   task automatic applyStimulus(input logic [15:0] w, input logic v,
                                input logic dr, input logic b, input logic sm);
      logic acc, pulse;
      instr = w; instr_valid = v; dec_ready = dr; btn = b; step_mode = sm;
      #1;
      checkAll();
      acc   = v && exp_ready;
      pulse = m_hist[2] && !m_hist[3];
      @(posedge clk);
      if (m_valid && dr) m_count = m_count + 1;
      if (!m_halted) begin
         if (!sm) m_token = 0;
         else if (pulse) m_token = 1;
         else if (acc) m_token = 0;
      end
      if (acc && w[15:12] == 4'hF) m_halted = 1;
      if (acc) begin
         m_instr = w;
         m_valid = 1;
      end else if (dr) begin
         m_valid = 0;
      end
      m_prev_mode = sm;
      m_hist = {m_hist[2:0], b};
      @(negedge clk);
   endtask

   task automatic doReset(input logic sm);
      rst = 1; instr_valid = 0; btn = 0; step_mode = sm; dec_ready = 0;
      #1;
      checkOutput("rst_dec_valid", 32'(dec_valid), 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_retired", 32'(retired), 32'd0);
      checkOutput("rst_instr_ready", 32'(instr_ready), 32'd0);
      checkOutput("rst_fields", 32'({opcode, rd_addr, rs_addr, imm}), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      modelReset();
   endtask

   initial begin
      int seen;
      int halt_age;
      logic [15:0] w;
      logic sm, b;
      rst = 1; instr = '0; instr_valid = 0; btn = 0; step_mode = 0; dec_ready = 0;
      modelReset();
      @(negedge clk);
      doReset(1'b0);

      // Free run with dec_ready high
      applyStimulus(16'h237B, 1, 1, 0, 0);
      checkOutput("ex_opcode", 32'(opcode), 32'd2);
      checkOutput("ex_rd_rs", 32'({rd_addr, rs_addr}), 32'h37);
      checkOutput("ex_imm", 32'(imm), 32'h7B);
      checkOutput("ex_enables", 32'({rd_en, rs_en, wr_en, imm_en}), 32'b1110);
      applyStimulus(16'h1018, 1, 1, 0, 0);
      checkOutput("ldi_enables", 32'({rd_en, rs_en, wr_en, imm_en}), 32'b1011);
      applyStimulus(16'hC844, 1, 1, 0, 0);
      applyStimulus(16'h0000, 0, 1, 0, 0);
      checkOutput("free_retired", 32'(retired), 32'd3);
      applyStimulus(16'h0000, 1, 1, 0, 0);
      applyStimulus(16'h5123, 1, 1, 0, 0);
      applyStimulus(16'h0000, 0, 1, 0, 0);
      checkOutput("wrap_retired_w2", 32'(u2_retired), 32'd1);

      // Backpressure: outputs frozen for 4 cycles, then the next follows
      applyStimulus(16'h237B, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(16'h1018, 1, 0, 0, 0);
      checkOutput("bp_held_opcode", 32'(opcode), 32'd2);
      applyStimulus(16'h1018, 1, 1, 0, 0);
      checkOutput("bp_next_opcode", 32'(opcode), 32'd1);
      applyStimulus(16'h0000, 0, 1, 0, 0);
      checkOutput("bp_retired", 32'(retired), 32'd7);

      // Step mode: nothing without a press, one press gives one instruction
      doReset(1'b1);
      seen = 0;
      for (int i = 0; i < 6; i++) applyStimulus(16'h1018, 1, 1, 0, 1);
      checkOutput("step_idle_valid", 32'(dec_valid), 32'd0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(16'h2345, 1, 1, (i < 2) ? 1'b1 : 1'b0, 1);
         if (dec_valid) seen++;
      end
      checkOutput("step_one_press", 32'(seen), 32'd1);
      // Two presses while nothing is presented saturate the token
      seen = 0;
      for (int i = 0; i < 8; i++)
         applyStimulus(16'h0000, 0, 1, (i == 0 || i == 2) ? 1'b1 : 1'b0, 1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(16'h3456, 1, 1, 0, 1);
         if (dec_valid) seen++;
      end
      checkOutput("step_two_press", 32'(seen), 32'd1);

      // HALT drains, later instruction never taken
      doReset(1'b0);
      applyStimulus(16'h1005, 1, 1, 0, 0);
      applyStimulus(16'hF000, 1, 1, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(16'h2340, 1, 1, 0, 0);
      checkOutput("halt_flag", 32'(halted), 32'd1);
      checkOutput("halt_retired", 32'(retired), 32'd2);

      // Reset while a HALT is held and halted is set
      doReset(1'b0);
      applyStimulus(16'h1005, 1, 1, 0, 0);
      applyStimulus(16'hF000, 1, 1, 0, 0);
      applyStimulus(16'h2340, 1, 0, 0, 0);
      checkOutput("pre_rst_valid_halt", 32'({dec_valid, halted}), 32'b11);
      doReset(1'b0);
      applyStimulus(16'h1018, 1, 1, 0, 0);
      checkOutput("post_rst_fields", 32'({opcode, imm}), 32'h118);
      applyStimulus(16'h0000, 0, 1, 0, 0);

      // Randomised traffic across modes, presses, stalls and halts
      sm = 0; b = 0; halt_age = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 39) == 0) sm = ~sm;
         if ($urandom_range(0, 5) == 0) b = ~b;
         w = 16'($urandom);
         if (w[15:12] == 4'hF && $urandom_range(0, 9) != 0) w[15] = 1'b0;
         applyStimulus(w, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7), b, sm);
         if (m_halted) halt_age++;
         if (halt_age > 8) begin
            halt_age = 0;
            doReset(sm);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
